// File: rtl/weight_loader_if.sv
// Stream-in / bank-write bundle for weight_loader: the weight word stream and the write port to the bank.
// Latency: none (wires only).
// Backpressure: in_ready is driven by the loader; the bank side has no flow control.
//
// Signals:
//   in_valid, in_data  : weight word stream (producer -> loader)
//   in_ready           : loader accepts the word this cycle
//   write_enable       : one-cycle write strobe to the bank
//   layer, node        : bank address of the word being written
//   data_out           : word being written
interface weight_loader_if #(
    parameter int LAYER_SIZE  = 4,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 16
);
    localparam int NW = $clog2(LAYER_SIZE);
    localparam int LW = $clog2(LAYER_DEPTH);

    logic                in_valid;
    logic                in_ready;
    logic [BIT_SIZE-1:0] in_data;
    logic                write_enable;
    logic [LW-1:0]       layer;
    logic [NW-1:0]       node;
    logic [BIT_SIZE-1:0] data_out;

    // The loader side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output write_enable,
        output layer,
        output node,
        output data_out
    );

    // The producer/bank side.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  write_enable,
        input  layer,
        input  node,
        input  data_out
    );
endinterface

// File: rtl/weight_loader.sv
// Feeds a weight stream into the per-node weight bank, node-fastest then layer, LAYER_SIZE*LAYER_DEPTH words per load.
// Latency: 1 cycle from stream acceptance to write strobe; done pulses together with the last strobe.
// Backpressure: in_ready is high only in LOAD with abort low; one word per cycle sustained, no bubbles.
//
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start, abort : start a load (sampled in IDLE only), synchronous cancel
//   busy, done   : high while loading, one-cycle pulse with the final write
//   bus          : weight_loader_if.slave (stream in, bank write out)
//   checksum     : running sum of accepted words, present only with WEIGHT_LOADER_CHECKSUM_EN
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN
module weight_loader #(
    parameter int LAYER_SIZE  = 4,
    parameter int LAYER_DEPTH = 4,
    parameter int BIT_SIZE    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic [BIT_SIZE-1:0] checksum,
`endif
    weight_loader_if.slave      bus
);
    localparam int NW = $clog2(LAYER_SIZE);
    localparam int LW = $clog2(LAYER_DEPTH);
    localparam logic [NW-1:0] NODE_LAST  = NW'(LAYER_SIZE - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(LAYER_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [NW-1:0]       node_cnt_q,  node_cnt_d;
    logic [LW-1:0]       layer_cnt_q, layer_cnt_d;
    logic                last_word;
    logic                accept;
    logic                we_q;
    logic                done_q;
    logic [NW-1:0]       node_q;
    logic [LW-1:0]       layer_q;
    logic [BIT_SIZE-1:0] data_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [BIT_SIZE-1:0] checksum_q;
`endif

    assign bus.in_ready = (state_q == S_LOAD) && !abort;
    assign accept       = bus.in_valid && bus.in_ready;

    // Explicit wrap at LAYER_SIZE-1 keeps addressing correct for non-power-of-2 sizes.
    always_comb begin
        last_word   = (node_cnt_q == NODE_LAST) && (layer_cnt_q == LAYER_LAST);
        node_cnt_d  = node_cnt_q + 1'b1;
        layer_cnt_d = layer_cnt_q;
        if (node_cnt_q == NODE_LAST) begin
            node_cnt_d  = '0;
            layer_cnt_d = layer_cnt_q + 1'b1;
        end
        if (last_word) begin
            layer_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            node_cnt_q  <= '0;
            layer_cnt_q <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            node_q      <= '0;
            layer_q     <= '0;
            data_q      <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // abort outranks start
                    if (start && !abort) begin
                        state_q     <= S_LOAD;
                        node_cnt_q  <= '0;
                        layer_cnt_q <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        checksum_q  <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        node_cnt_q  <= '0;
                        layer_cnt_q <= '0;
                    end else if (accept) begin
                        we_q        <= 1'b1;
                        node_q      <= node_cnt_q;
                        layer_q     <= layer_cnt_q;
                        data_q      <= bus.in_data;
                        node_cnt_q  <= node_cnt_d;
                        layer_cnt_q <= layer_cnt_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                        checksum_q  <= checksum_q + bus.in_data;
`endif
                        // done rides alongside the final write strobe
                        if (last_word) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = (state_q == S_LOAD);
    assign done             = done_q;
    assign bus.write_enable = we_q;
    assign bus.node         = node_q;
    assign bus.layer        = layer_q;
    assign bus.data_out     = data_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    assign checksum         = checksum_q;
`endif

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Upstream feeder for the per-node weight memory bank.
- Accepts a valid/ready stream of weight words and turns it into the bank's write interface: write_enable, layer index, node index and data word.
- Words are ordered node-fastest, then layer: word k goes to node = k mod LAYER_SIZE, layer = k / LAYER_SIZE.
- One load sequence writes exactly LAYER_SIZE*LAYER_DEPTH words, then signals done.

Parameters:
- LAYER_SIZE, 4, nodes per layer; must be >= 2.
- LAYER_DEPTH, 4, number of layers; must be >= 2.
- BIT_SIZE, 16, weight word width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a load sequence; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader accepts word this cycle.
- in_data  in  BIT_SIZE  stream word.
- write_enable  out  1  write strobe to the memory bank.
- layer  out  $clog2(LAYER_DEPTH)  target layer.
- node  out  $clog2(LAYER_SIZE)  target node.
- data_out  out  BIT_SIZE  word to write.
- busy  out  1  high in LOAD.
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, all outputs 0, node/layer counters 0.
- States:
  - IDLE: start=1 -> LOAD, counters cleared.
  - LOAD: accepts words; after the final word is accepted -> DONE.
  - DONE: asserts done for one cycle -> IDLE.
- in_ready = (state==LOAD) && !abort. A word is accepted when in_valid && in_ready.
- All write outputs are registered; latency is 1 cycle.
  - Write cycle: write_enable=1 on the cycle after acceptance, with node/layer/data_out equal to that word's address and data.
  - Idle cycles: write_enable=0; node/layer/data_out hold their last values.
- Counter advance on each acceptance:
  - node increments.
  - When node == LAYER_SIZE-1, node wraps to 0 and layer increments. The wrap is explicit, not power-of-2 overflow, so it is correct for non-power-of-2 sizes.
  - When node == LAYER_SIZE-1 and layer == LAYER_DEPTH-1, the word is the last one. State -> DONE; the last write strobe appears in the same cycle as done.
- Back-to-back: one word per cycle sustained; no bubbles inserted.
- in_valid low mid-sequence: no write, counters hold, busy stays 1.
- start while in LOAD or DONE is ignored.
- start and abort both high in IDLE: abort wins, stay IDLE.
- abort in LOAD:
  - The next cycle is IDLE with counters cleared and no done pulse.
  - A word accepted in the cycle before abort still produces its write strobe.
  - in_ready is 0 during the abort cycle.
- abort in DONE: done still pulses; state -> IDLE.
- Reset mid-sequence: immediate return to IDLE; write_enable drops asynchronously; no done.
- busy = (state==LOAD); combinational from state.

Optional Feature:
- Macro WEIGHT_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [BIT_SIZE-1:0].
  - It is the running sum, modulo 2^BIT_SIZE, of all words accepted in the current sequence.
  - Cleared on start and on reset.
  - Updated in the same registered cycle as data_out.
  - Holds its value after done until the next start.
  - Abort does not clear it.
- Undefined: no checksum port, no adder; all other behaviour identical.

Test Plan (LAYER_SIZE=3, LAYER_DEPTH=2 unless stated):
- Basic load: reset, pulse start, stream 6 words 0x0001..0x0006 with in_valid held high -> six consecutive write_enable cycles with (layer,node,data_out) = (0,0,1),(0,1,2),(0,2,3),(1,0,4),(1,1,5),(1,2,6); done=1 coincident with the 6th strobe; busy=0 the following cycle.
- Gapped input: same 6 words with in_valid low every other cycle -> writes only one cycle after each acceptance; addresses identical to the basic load; no spurious strobes.
- Abort: abort high in the cycle after the 3rd acceptance -> exactly 3 writes; no done; state IDLE. A new start then loads 6 words beginning at (0,0).
- Async reset mid-load: drop rst_n between clock edges after word 2 -> write_enable and busy go 0 immediately. After release, start reloads from (0,0).
- Ignored start: pulse start during LOAD and during DONE -> no counter reset, exactly 6 writes, one done.
- Checksum (macro defined): words 0xFFFF,0x0002,0x0003,0x0004,0x0005,0x0006 -> checksum=0x0013 after done; holds until the next start.
